eth_tlp_encap_arb: RTL and testbench

ETH_TLP_ENCAP_ARB -- requirements
Module: eth_tlp_encap_arb

---
 rtl/eth_encap_pkg.sv | 36 +++
 rtl/eth_rr_arb.sv | 29 ++
 rtl/eth_tlp_encap_arb.sv | 164 ++++++++++++++++
 tb/tb_eth_tlp_encap_arb.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_encap_pkg.sv
// eth_encap_pkg: FIFO word layout, encapsulation FSM states and header helpers
// shared by the Ethernet TLP encapsulating arbiter.
package eth_encap_pkg;

   localparam int FIFO_W = 74;

   typedef struct packed {
      logic        rsvd;
      logic        last;
      logic [7:0]  keep;
      logic [63:0] data;
   } fifo_word_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR0    = 3'd1,
      HDR1    = 3'd2,
      PAYLOAD = 3'd3,
      DRAIN   = 3'd4,
      GAP     = 3'd5
   } state_t;

   // Wire order: byte 0 is the first octet on the line (MAC MSB first).
   function automatic logic [63:0] hdr0_word(logic [47:0] dst, logic [47:0] src);
      return {src[39:32], src[47:40],
              dst[7:0], dst[15:8], dst[23:16],
              dst[31:24], dst[39:32], dst[47:40]};
   endfunction

   function automatic logic [63:0] hdr1_word(logic [47:0] src, logic [15:0] etype,
                                             logic [7:0] ch, logic [7:0] seq);
      return {seq, ch, etype[7:0], etype[15:8],
              src[7:0], src[15:8], src[23:16], src[31:24]};
   endfunction

endpackage

// File: rtl/eth_rr_arb.sv
// eth_rr_arb: combinational round-robin pick; search starts one past
// the previous grant and wraps modulo NCH.
module eth_rr_arb
   import eth_encap_pkg::*;
#(
   parameter int NCH = 2,
   parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  last_grant,
   output logic [IW-1:0]  grant,
   output logic           grant_vld
);

   // Walk from farthest to nearest so the nearest requester wins.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      for (int i = NCH; i >= 1; i--) begin
         int c;
         c = (int'(last_grant) + i) % NCH;
         if (req[c]) begin
            grant     = IW'(c);
            grant_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tlp_encap_arb.sv
// eth_tlp_encap_arb: arbitrates TLP FIFOs and wraps each TLP in an Ethernet frame.
// Define ETH_ENCAP_SEQ_EN for a per-channel sequence byte in the second header beat.
module eth_tlp_encap_arb
   import eth_encap_pkg::*;
#(
   parameter int          NCH        = 2,
   parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
   parameter logic [15:0] ETHERTYPE  = 16'h88B5,
   parameter logic [15:0] IFG_CYCLES = 16'd8,
   parameter logic [7:0]  STALL_MAX  = 8'd32
) (
   input  logic                       clk156,
   input  logic                       sys_rst,
   output logic [NCH-1:0]             rd_en,
   input  logic [NCH-1:0][FIFO_W-1:0] dout,
   input  logic [NCH-1:0]             empty,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [63:0]                m_axis_tdata,
   output logic [7:0]                 m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tuser,
   output logic [31:0]                frame_cnt,
   output logic [15:0]                abort_cnt
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   state_t     state;
   logic [IW-1:0] g;
   logic [IW-1:0] last_grant;
   logic [IW-1:0] pick;
   logic       pick_vld;
   logic [7:0] stall_cnt;
   logic [15:0] gap_cnt;
   logic [7:0] seq_byte;
   fifo_word_t w;
   logic       stalled;
   logic       beat;

   assign w       = fifo_word_t'(dout[g]);
   assign stalled = (stall_cnt == STALL_MAX);
   assign beat    = m_axis_tvalid & m_axis_tready;

   eth_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
      .req        (~empty),
      .last_grant (last_grant),
      .grant      (pick),
      .grant_vld  (pick_vld)
   );

`ifdef ETH_ENCAP_SEQ_EN
   logic [7:0] seq [NCH];

   // Any tlast beat in PAYLOAD ends the frame, including the abort beat.
   always_ff @(posedge clk156) begin
      if (sys_rst) begin
         for (int i = 0; i < NCH; i++) seq[i] <= 8'h00;
      end else if (state == PAYLOAD && beat && m_axis_tlast) begin
         seq[g] <= seq[g] + 8'h01;
      end
   end

   assign seq_byte = seq[g];
`else
   assign seq_byte = 8'h00;
`endif

   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      rd_en         = '0;
      unique case (state)
         HDR0: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = hdr0_word(DST_MAC, SRC_MAC);
            m_axis_tkeep  = 8'hFF;
         end
         HDR1: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = hdr1_word(SRC_MAC, ETHERTYPE, 8'(g), seq_byte);
            m_axis_tkeep  = 8'hFF;
         end
         PAYLOAD: begin
            if (stalled) begin
               m_axis_tvalid = 1'b1;
               m_axis_tkeep  = 8'h01;
               m_axis_tlast  = 1'b1;
               m_axis_tuser  = 1'b1;
            end else begin
               m_axis_tvalid = !empty[g];
               m_axis_tdata  = w.data;
               m_axis_tkeep  = w.keep;
               m_axis_tlast  = w.last;
               rd_en[g]      = !empty[g] & m_axis_tready;
            end
         end
         DRAIN: rd_en[g] = !empty[g];
         default: ;
      endcase
   end

   always_ff @(posedge clk156) begin
      if (sys_rst) begin
         state      <= IDLE;
         g          <= '0;
         last_grant <= IW'(NCH - 1);
         stall_cnt  <= '0;
         gap_cnt    <= '0;
         frame_cnt  <= '0;
         abort_cnt  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  g          <= pick;
                  last_grant <= pick;
                  state      <= HDR0;
               end
            end
            HDR0: if (beat) state <= HDR1;
            HDR1: begin
               if (beat) begin
                  state     <= PAYLOAD;
                  stall_cnt <= '0;
               end
            end
            PAYLOAD: begin
               if (stalled) begin
                  if (m_axis_tready) begin
                     state <= DRAIN;
                     if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
                  end
               end else if (rd_en[g]) begin
                  stall_cnt <= '0;
                  if (w.last) begin
                     frame_cnt <= frame_cnt + 32'd1;
                     gap_cnt   <= '0;
                     state     <= (IFG_CYCLES == 16'd0) ? IDLE : GAP;
                  end
               end else if (empty[g]) begin
                  stall_cnt <= stall_cnt + 8'd1;
               end
            end
            DRAIN: begin
               if (rd_en[g] && w.last) begin
                  gap_cnt <= '0;
                  state   <= (IFG_CYCLES == 16'd0) ? IDLE : GAP;
               end
            end
            GAP: begin
               if (gap_cnt == IFG_CYCLES - 16'd1) state <= IDLE;
               else gap_cnt <= gap_cnt + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tlp_encap_arb.sv
// tb_eth_tlp_encap_arb: scoreboard bench for the Ethernet TLP encapsulating arbiter
// with a queue-based FWFT FIFO model per channel.
module tb_eth_tlp_encap_arb;

   localparam int          NCH  = 2;
   localparam logic [47:0] DST  = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] SRC  = 48'h0200_0000_0001;
   localparam logic [15:0] ET   = 16'h88B5;
   localparam logic [15:0] IFG  = 16'd8;
   localparam logic [7:0]  SMAX = 8'd32;

   typedef struct packed {
      logic        user;
      logic        last;
      logic [7:0]  keep;
      logic [63:0] data;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NCH-1:0]        rd_en;
   logic [NCH-1:0][73:0]  dout;
   logic [NCH-1:0]        empty;
   logic                  tvalid, tready, tlast, tuser;
   logic [63:0]           tdata;
   logic [7:0]            tkeep;
   logic [31:0]           frame_cnt;
   logic [15:0]           abort_cnt;

   logic [73:0] fq [NCH][$];
   beat_t       exp_q[$];
   beat_t       obs_q[$];
   int          obs_t[$];
   int          cyc = 0;
   logic [NCH-1:0] pend = '0;
   logic [7:0]  mseq [NCH];
   int          n_chk = 0;
   int          n_fail = 0;

   eth_tlp_encap_arb #(
      .NCH(NCH), .DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ET),
      .IFG_CYCLES(IFG), .STALL_MAX(SMAX)
   ) dut (
      .clk156(clk), .sys_rst(rst), .rd_en(rd_en), .dout(dout), .empty(empty),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
      .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
      .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
   );

   always #5 clk = ~clk;

   task automatic upd();
      for (int c = 0; c < NCH; c++) begin
         empty[c] = (fq[c].size() == 0);
         dout[c]  = empty[c] ? 74'd0 : fq[c][0];
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc = cyc + 1;

   // Handshakes seen at the negedge complete on the following posedge.
   always @(negedge clk) begin
      if (!rst && tvalid && tready) begin
         obs_q.push_back({tuser, tlast, tkeep, tdata});
         obs_t.push_back(cyc);
      end
      pend = rd_en;
   end

   always @(posedge clk) begin
      #1;
      for (int c = 0; c < NCH; c++)
         if (pend[c] && fq[c].size() > 0) void'(fq[c].pop_front());
      upd();
   end

   function automatic beat_t h0();
      beat_t b;
      logic [47:0] d;
      logic [47:0] s;
      d = DST;
      s = SRC;
      b = '0;
      b.keep = 8'hFF;
      for (int i = 0; i < 6; i++) b.data[8*i +: 8] = d[8*(5-i) +: 8];
      b.data[55:48] = s[47:40];
      b.data[63:56] = s[39:32];
      return b;
   endfunction

   function automatic beat_t h1(int ch, logic [7:0] sq);
      beat_t b;
      logic [47:0] s;
      logic [15:0] e;
      s = SRC;
      e = ET;
      b = '0;
      b.keep = 8'hFF;
      for (int i = 0; i < 4; i++) b.data[8*i +: 8] = s[8*(3-i) +: 8];
      b.data[39:32] = e[15:8];
      b.data[47:40] = e[7:0];
      b.data[55:48] = 8'(ch);
      b.data[63:56] = sq;
      return b;
   endfunction

   function automatic logic [7:0] next_seq(int ch);
      logic [7:0] sq;
`ifdef ETH_ENCAP_SEQ_EN
      sq = mseq[ch];
      mseq[ch] = mseq[ch] + 8'd1;
`else
      sq = 8'h00;
`endif
      return sq;
   endfunction

   task automatic push_frame(int ch, int n, logic [63:0] base, logic [7:0] lk);
      beat_t b;
      exp_q.push_back(h0());
      exp_q.push_back(h1(ch, next_seq(ch)));
      for (int i = 0; i < n; i++) begin
         b.user = 1'b0;
         b.last = (i == n - 1);
         b.keep = b.last ? lk : 8'hFF;
         b.data = base + 64'(i);
         exp_q.push_back(b);
         fq[ch].push_back({1'b0, b.last, b.keep, b.data});
      end
   endtask

   task automatic clear_all();
      for (int c = 0; c < NCH; c++) begin
         fq[c].delete();
         mseq[c] = 8'h00;
      end
      exp_q.delete();
      obs_q.delete();
      obs_t.delete();
      upd();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tready = 1'b1;
      clear_all();
      repeat (3) step();
      @(negedge clk);
      n_chk++;
      if ({tvalid, tlast, tuser} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctl got %b want 000", {tvalid, tlast, tuser});
      end
      n_chk++;
      if ({tdata, tkeep} !== 72'd0) begin
         n_fail++;
         $display("FAIL reset_data got %h want 0", {tdata, tkeep});
      end
      n_chk++;
      if (rd_en !== '0) begin
         n_fail++;
         $display("FAIL reset_rd_en got %b want 0", rd_en);
      end
      n_chk++;
      if (frame_cnt !== 32'd0 || abort_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_cnt got %0d/%0d want 0/0", frame_cnt, abort_cnt);
      end
      step();
      rst = 1'b0;
   endtask

   task automatic test_single();
      beat_t e, o;
      push_frame(0, 3, 64'hA0A0_0000_0000_0010, 8'h0F);
      upd();
      for (int k = 0; k < 100 && frame_cnt != 32'd1; k++) step();
      n_chk++;
      if (frame_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL single_frame_cnt got %0d want 1", frame_cnt);
      end
      n_chk++;
      if (obs_q.size() !== 5) begin
         n_fail++;
         $display("FAIL single_count got %0d want 5", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         void'(obs_t.pop_front());
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL single_beat got %h want %h", o, e);
         end
      end
      clear_all();
   endtask

   task automatic test_round_robin();
      beat_t e, o;
      int t, pt;
      logic pl;
      rst = 1'b1;
      step();
      step();
      clear_all();
      rst = 1'b0;
      push_frame(0, 2, 64'h0000_0000_0000_0100, 8'hFF);
      push_frame(1, 4, 64'h1111_0000_0000_0200, 8'h01);
      push_frame(0, 1, 64'h0000_0000_0000_0300, 8'h3F);
      push_frame(1, 3, 64'h1111_0000_0000_0400, 8'h07);
      upd();
      for (int k = 0; k < 400 && frame_cnt != 32'd4; k++) step();
      n_chk++;
      if (frame_cnt !== 32'd4) begin
         n_fail++;
         $display("FAIL rr_frame_cnt got %0d want 4", frame_cnt);
      end
      n_chk++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL rr_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      pl = 1'b0;
      pt = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         t = obs_t.pop_front();
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL rr_beat got %h want %h", o, e);
         end
         if (pl) begin
            n_chk++;
            if (t - pt - 1 < int'(IFG)) begin
               n_fail++;
               $display("FAIL rr_ifg got %0d idle want >= %0d", t - pt - 1, IFG);
            end
         end
         pl = o.last;
         pt = t;
      end
      clear_all();
   endtask

   task automatic test_stall_abort();
      beat_t e, o, b;
      logic [31:0] fc0;
      fc0 = frame_cnt;
      exp_q.push_back(h0());
      exp_q.push_back(h1(0, next_seq(0)));
      b = '{user: 1'b0, last: 1'b0, keep: 8'hFF, data: 64'hDEAD_0000_0000_0001};
      exp_q.push_back(b);
      exp_q.push_back('{user: 1'b1, last: 1'b1, keep: 8'h01, data: 64'd0});
      fq[0].push_back({2'b00, b.keep, b.data});
      upd();
      for (int k = 0; k < 200 && abort_cnt != 16'd1; k++) step();
      n_chk++;
      if (abort_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL stall_abort_cnt got %0d want 1", abort_cnt);
      end
      fq[0].push_back({2'b00, 8'hFF, 64'hDEAD_0000_0000_0002});
      fq[0].push_back({2'b00, 8'hFF, 64'hDEAD_0000_0000_0003});
      fq[0].push_back({2'b01, 8'h03, 64'hDEAD_0000_0000_0004});
      upd();
      for (int k = 0; k < 50 && fq[0].size() != 0; k++) step();
      n_chk++;
      if (fq[0].size() !== 0) begin
         n_fail++;
         $display("FAIL stall_drain got %0d words left want 0", fq[0].size());
      end
      repeat (12) step();
      n_chk++;
      if (frame_cnt !== fc0) begin
         n_fail++;
         $display("FAIL stall_frame_cnt got %0d want %0d", frame_cnt, fc0);
      end
      push_frame(0, 2, 64'h0000_BEEF_0000_0001, 8'h1F);
      upd();
      for (int k = 0; k < 100 && frame_cnt != fc0 + 32'd1; k++) step();
      n_chk++;
      if (frame_cnt !== fc0 + 32'd1) begin
         n_fail++;
         $display("FAIL stall_next_frame got %0d want %0d", frame_cnt, fc0 + 1);
      end
      n_chk++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         void'(obs_t.pop_front());
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL stall_beat got %h want %h", o, e);
         end
      end
      clear_all();
   endtask

   task automatic test_backpressure();
      beat_t e, o, hv, pv;
      logic [31:0] fc0;
      fc0 = frame_cnt;
      tready = 1'b1;
      push_frame(1, 4, 64'h5555_0000_0000_0001, 8'h07);
      upd();
      hv = exp_q[1];
      pv = exp_q[3];
      for (int k = 0; k < 50 && obs_q.size() < 1; k++) step();
      tready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_chk++;
         if (tvalid !== 1'b1 || tdata !== hv.data || tkeep !== hv.keep || rd_en !== '0) begin
            n_fail++;
            $display("FAIL bp_hdr1_hold got v%b %h/%h rd%b want v1 %h/%h rd0",
                     tvalid, tdata, tkeep, rd_en, hv.data, hv.keep);
         end
         step();
      end
      tready = 1'b1;
      for (int k = 0; k < 50 && obs_q.size() < 3; k++) step();
      tready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_chk++;
         if (tvalid !== 1'b1 || tdata !== pv.data || tkeep !== pv.keep || rd_en !== '0) begin
            n_fail++;
            $display("FAIL bp_payload_hold got v%b %h/%h rd%b want v1 %h/%h rd0",
                     tvalid, tdata, tkeep, rd_en, pv.data, pv.keep);
         end
         step();
      end
      tready = 1'b1;
      for (int k = 0; k < 100 && frame_cnt != fc0 + 32'd1; k++) step();
      n_chk++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         void'(obs_t.pop_front());
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL bp_beat got %h want %h", o, e);
         end
      end
      clear_all();
   endtask

   task automatic test_seq_wrap();
      beat_t e, o;
      rst = 1'b1;
      step();
      step();
      clear_all();
      rst = 1'b0;
      for (int i = 0; i < 257; i++)
         push_frame(1, 1, 64'h7000_0000_0000_0000 + 64'(i), 8'hFF);
      upd();
      for (int k = 0; k < 257 * 16 && frame_cnt != 32'd257; k++) step();
      n_chk++;
      if (frame_cnt !== 32'd257) begin
         n_fail++;
         $display("FAIL seq_frame_cnt got %0d want 257", frame_cnt);
      end
      n_chk++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL seq_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         void'(obs_t.pop_front());
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL seq_beat got %h want %h", o, e);
         end
      end
      clear_all();
   endtask

   task automatic test_reset_mid();
      beat_t e, o;
      push_frame(1, 6, 64'h9999_0000_0000_0001, 8'hFF);
      upd();
      for (int k = 0; k < 50 && obs_q.size() < 3; k++) step();
      rst = 1'b1;
      step();
      @(negedge clk);
      n_chk++;
      if ({tvalid, tlast, tuser, tdata, tkeep, rd_en} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_outputs got v%b l%b u%b %h/%h rd%b want all 0",
                  tvalid, tlast, tuser, tdata, tkeep, rd_en);
      end
      n_chk++;
      if (frame_cnt !== 32'd0 || abort_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rstmid_cnt got %0d/%0d want 0/0", frame_cnt, abort_cnt);
      end
      step();
      clear_all();
      push_frame(0, 2, 64'hC000_0000_0000_0001, 8'h0F);
      push_frame(1, 2, 64'hC111_0000_0000_0001, 8'hFF);
      upd();
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (tvalid !== 1'b0 || rd_en !== '0) begin
         n_fail++;
         $display("FAIL rstmid_idle got v%b rd%b want v0 rd0", tvalid, rd_en);
      end
      for (int k = 0; k < 200 && frame_cnt != 32'd2; k++) step();
      n_chk++;
      if (obs_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         void'(obs_t.pop_front());
         n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL rstmid_beat got %h want %h", o, e);
         end
      end
      clear_all();
   endtask

   initial begin
      tready = 1'b1;
      clear_all();
      test_reset();
      test_single();
      test_round_robin();
      test_stall_abort();
      test_backpressure();
      test_seq_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
